// File: rtl/ldr_scan_sequencer.sv
// Round-robin scan of four photoresistor channels through a shared ADC.
// Each channel is settled, oversampled and averaged; results commit as one frame.
module ldr_scan_sequencer #(
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic        adc_start,
    output logic [1:0]  adc_ch,
    output logic [15:0] r_v1,
    output logic [15:0] r_v2,
    output logic [15:0] r_h1,
    output logic [15:0] r_h2,
    output logic        frame_valid,
    output logic        adc_timeout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_ACCUM  = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;

    localparam logic [4:0] NSAMP = 5'(1 << AVG_LOG2);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [1:0]  r_ch;
    logic [7:0]  r_settle_cnt;
    logic [15:0] r_wait_cnt;
    logic [4:0]  r_samp_cnt;
    logic [15:0] r_acc;
    logic [11:0] r_sample;
    logic        r_abort;
    logic        r_fv;
    logic        r_to;
    logic [15:0] r_shadow [4];
    logic [15:0] r_out    [4];

    logic        w_settle_done;
    logic        w_wait_expired;
    logic [4:0]  w_samp_next;
    logic        w_last_samp;
    logic [15:0] w_avg;
    logic        w_stop;

    assign w_settle_done  = (r_settle_cnt == 8'(SETTLE - 1));
    assign w_wait_expired = (r_wait_cnt == 16'(TIMEOUT - 1));
    assign w_samp_next    = r_samp_cnt + 5'd1;
    assign w_last_samp    = (w_samp_next == NSAMP);
    assign w_avg          = r_acc >> AVG_LOG2;
    // Enable dropped mid-conversion: finish the conversion, then park in IDLE.
    assign w_stop         = r_abort || !enable;

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_next = enable ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: begin
                if (!enable)           w_state_next = ST_IDLE;
                else if (w_settle_done) w_state_next = ST_START;
                else                   w_state_next = ST_SETTLE;
            end
            ST_START:  w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (adc_done)            w_state_next = ST_ACCUM;
                else if (w_wait_expired) w_state_next = w_stop ? ST_IDLE : ST_SETTLE;
                else                     w_state_next = ST_WAIT;
            end
            ST_ACCUM: begin
                if (w_stop)           w_state_next = ST_IDLE;
                else if (w_last_samp) w_state_next = ST_NEXT;
                else                  w_state_next = ST_START;
            end
            ST_NEXT:   w_state_next = (r_ch == 2'd3 && !enable) ? ST_IDLE : ST_SETTLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ch         <= 2'd0;
            r_settle_cnt <= 8'd0;
            r_wait_cnt   <= 16'd0;
            r_samp_cnt   <= 5'd0;
            r_acc        <= 16'd0;
            r_sample     <= 12'd0;
            r_abort      <= 1'b0;
            r_fv         <= 1'b0;
            r_to         <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 16'd0;
                r_out[i]    <= 16'd0;
            end
        end else begin
            r_state      <= w_state_next;
            r_fv         <= 1'b0;
            r_settle_cnt <= (r_state == ST_SETTLE && w_state_next == ST_SETTLE) ?
                            r_settle_cnt + 8'd1 : 8'd0;
            if ((r_state == ST_START || r_state == ST_WAIT) && !enable) begin
                r_abort <= 1'b1;
            end
            if (w_state_next == ST_IDLE) begin
                r_abort <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_ch       <= 2'd0;
                    r_samp_cnt <= 5'd0;
                    r_acc      <= 16'd0;
                end
                ST_START: r_wait_cnt <= 16'd0;
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                    if (adc_done) begin
                        r_sample <= adc_data;
                    end else if (w_wait_expired) begin
                        r_to       <= 1'b1;
                        r_acc      <= 16'd0;
                        r_samp_cnt <= 5'd0;
                        r_ch       <= 2'd0;
                    end
                end
                ST_ACCUM: begin
                    if (w_stop) begin
                        r_acc      <= 16'd0;
                        r_samp_cnt <= 5'd0;
                        r_ch       <= 2'd0;
                    end else begin
                        r_acc      <= r_acc + {4'd0, r_sample};
                        r_samp_cnt <= w_samp_next;
                    end
                end
                ST_NEXT: begin
                    r_shadow[r_ch] <= w_avg;
                    r_acc          <= 16'd0;
                    r_samp_cnt     <= 5'd0;
                    r_ch           <= r_ch + 2'd1;
                    // Channel 3's average is still in flight, so take it directly.
                    if (r_ch == 2'd3) begin
                        r_out[0] <= r_shadow[0];
                        r_out[1] <= r_shadow[1];
                        r_out[2] <= r_shadow[2];
                        r_out[3] <= w_avg;
                        r_fv     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign adc_start   = (r_state == ST_START);
    assign adc_ch      = r_ch;
    assign r_v1        = r_out[0];
    assign r_v2        = r_out[1];
    assign r_h1        = r_out[2];
    assign r_h2        = r_out[3];
    assign frame_valid = r_fv;
    assign adc_timeout = r_to;

endmodule

// File: tb/tb_ldr_scan_sequencer.sv
// Directed bench for ldr_scan_sequencer with a fixed-latency ADC model.
// A second instance (AVG_LOG2=0, short settle) checks the no-averaging path.
module tb_ldr_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        adc_start;
    logic [1:0]  adc_ch;
    logic [15:0] r_v1, r_v2, r_h1, r_h2;
    logic        frame_valid;
    logic        adc_timeout;

    logic        enable2;
    logic        adc_done2;
    logic [11:0] adc_data2;
    logic        adc_start2;
    logic [1:0]  adc_ch2;
    logic [15:0] r2_v1, r2_v2, r2_h1, r2_h2;
    logic        frame_valid2;
    logic        adc_timeout2;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model controls, written only by the stimulus process.
    int base [4];
    int step     = 0;
    int model_en = 1;
    int epoch    = 0;
    int spur_seq = 0;

    ldr_scan_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .adc_start   (adc_start),
        .adc_ch      (adc_ch),
        .r_v1        (r_v1),
        .r_v2        (r_v2),
        .r_h1        (r_h1),
        .r_h2        (r_h2),
        .frame_valid (frame_valid),
        .adc_timeout (adc_timeout)
    );

    ldr_scan_sequencer #(
        .SETTLE   (2),
        .AVG_LOG2 (0),
        .TIMEOUT  (16)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable2),
        .adc_done    (adc_done2),
        .adc_data    (adc_data2),
        .adc_start   (adc_start2),
        .adc_ch      (adc_ch2),
        .r_v1        (r2_v1),
        .r_v2        (r2_v2),
        .r_h1        (r2_h1),
        .r_h2        (r2_h2),
        .frame_valid (frame_valid2),
        .adc_timeout (adc_timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model, L=5: done lands in the fifth WAIT cycle.
    int mcnt = 0;
    int n_done = 0;
    int epoch_seen = 0;
    int spur_seen = 0;
    initial begin
        adc_done = 1'b0;
        adc_data = 12'd0;
    end
    always @(negedge clk) begin
        if (epoch != epoch_seen) begin
            epoch_seen = epoch;
            n_done     = 0;
        end
        adc_done = 1'b0;
        if (spur_seq != spur_seen) begin
            spur_seen = spur_seq;
            adc_done  = 1'b1;
            adc_data  = 12'd4000;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                adc_done = 1'b1;
                adc_data = 12'(base[adc_ch] + step * (n_done % 4));
                n_done++;
            end
        end else if (adc_start === 1'b1 && model_en != 0) begin
            mcnt = 5;
        end
    end

    // Second ADC model, L=1, constant full-scale data.
    logic pend2 = 1'b0;
    assign adc_data2 = 12'hFFF;
    initial adc_done2 = 1'b0;
    always @(negedge clk) begin
        adc_done2 = pend2;
        pend2     = (adc_start2 === 1'b1);
    end

    // Monitors
    int fv_cnt = 0;
    int st_cnt = 0;
    int fv2_cnt = 0;
    int fv2_prev = 0;
    int fv2_last = 0;
    int log_on = 0;
    logic [1:0] ch_log [$];
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (adc_start === 1'b1) st_cnt++;
        if (frame_valid2 === 1'b1) begin
            fv2_cnt++;
            fv2_prev = fv2_last;
            fv2_last = cyc;
        end
        if (log_on != 0 && (ch_log.size() == 0 || adc_ch != ch_log[$])) ch_log.push_back(adc_ch);
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_fv(input string tag, input int limit);
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (frame_valid !== 1'b1 && n < limit);
        check({tag, "_fv_seen"}, 32'(frame_valid), 32'd1);
    endtask

    task automatic check_outs(input string tag, input int a, input int b, input int c,
                              input int d);
        check({tag, "_v1"}, 32'(r_v1), 32'(a));
        check({tag, "_v2"}, 32'(r_v2), 32'(b));
        check({tag, "_h1"}, 32'(r_h1), 32'(c));
        check({tag, "_h2"}, 32'(r_h2), 32'(d));
    endtask

    initial begin
        int t0;
        int fv0;
        int st0;
        int n;
        rst     = 1'b1;
        enable  = 1'b0;
        enable2 = 1'b1;
        base[0] = 100; base[1] = 200; base[2] = 300; base[3] = 400;
        tick;
        tick;
        check_outs("rst", 0, 0, 0, 0);
        check("rst_start", 32'(adc_start), 0);
        check("rst_ch", 32'(adc_ch), 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_to", 32'(adc_timeout), 0);
        rst = 1'b0;
        tick;

        // Constant per-channel data, frame period and channel order.
        enable = 1'b1;
        log_on = 1;
        wait_fv("const1", 400);
        check_outs("const1", 100, 200, 300, 400);
        t0 = cyc;
        tick;
        check("fv_one_cycle", 32'(frame_valid), 0);
        wait_fv("const2", 400);
        check("period", 32'(cyc - t0), 180);
        log_on = 0;
        check("ch_log_len", 32'(ch_log.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < ch_log.size()) check($sformatf("ch_seq%0d", i), 32'(ch_log[i]), 32'(i % 4));
        end

        // Stray adc_done while settling must not touch the accumulator.
        t0 = cyc;
        spur_seq++;
        wait_fv("spur", 400);
        check("spur_period", 32'(cyc - t0), 180);
        check_outs("spur", 100, 200, 300, 400);

        // Drop enable in SETTLE, then a fresh frame with ramping samples.
        enable = 1'b0;
        tick;
        tick;
        check("idle_start", 32'(adc_start), 0);
        check_outs("settle_drop", 100, 200, 300, 400);
        base[0] = 10; base[1] = 20; base[2] = 30; base[3] = 40;
        step = 1;
        epoch++;
        enable = 1'b1;
        wait_fv("ramp", 400);
        check_outs("ramp", 11, 21, 31, 41);

        // Drop enable during WAIT on channel 2.
        n = 0;
        while (!(adc_ch == 2'd2 && adc_start === 1'b1) && n < 400) begin
            tick;
            n++;
        end
        check("ch2_start_seen", 32'(adc_start), 1);
        tick;
        enable = 1'b0;
        fv0 = fv_cnt;
        st0 = st_cnt;
        repeat (40) tick;
        check("abort_no_fv", 32'(fv_cnt), 32'(fv0));
        check("abort_no_start", 32'(st_cnt), 32'(st0));
        check("abort_ch", 32'(adc_ch), 0);
        check_outs("abort", 11, 21, 31, 41);
        base[0] = 50; base[1] = 60; base[2] = 70; base[3] = 80;
        epoch++;
        enable = 1'b1;
        t0 = cyc;
        wait_fv("reenable", 400);
        check("reenable_latency", 32'(cyc - t0), 181);
        check_outs("reenable", 51, 61, 71, 81);

        // ADC never answers: timeout after 1024 WAIT cycles.
        enable = 1'b0;
        tick;
        tick;
        model_en = 0;
        fv0 = fv_cnt;
        enable = 1'b1;
        t0 = cyc;
        n = 0;
        while (adc_timeout !== 1'b1 && n < 2000) begin
            tick;
            n++;
        end
        check("to_flag", 32'(adc_timeout), 1);
        check("to_latency", 32'(cyc - t0), 1042);
        check("to_no_fv", 32'(fv_cnt), 32'(fv0));
        check("to_ch", 32'(adc_ch), 0);
        check_outs("to_hold", 51, 61, 71, 81);
        base[0] = 100; base[1] = 200; base[2] = 300; base[3] = 400;
        step = 0;
        epoch++;
        model_en = 1;
        t0 = cyc;
        wait_fv("to_restart", 400);
        check("to_restart_period", 32'(cyc - t0), 180);
        check_outs("to_restart", 100, 200, 300, 400);
        check("to_sticky", 32'(adc_timeout), 1);

        // No-averaging instance: full-scale passes through unchanged.
        check("avg0_frames", 32'(fv2_cnt >= 2), 1);
        check("avg0_period", 32'(fv2_last - fv2_prev), 24);
        check("avg0_v1", 32'(r2_v1), 32'd4095);
        check("avg0_h2", 32'(r2_h2), 32'd4095);
        check("avg0_to", 32'(adc_timeout2), 0);

        // Reset while accumulating on channel 3.
        n = 0;
        while (!(adc_done === 1'b1 && adc_ch == 2'd3) && n < 400) begin
            tick;
            n++;
        end
        check("ch3_done_seen", 32'(adc_done), 1);
        tick;
        rst = 1'b1;
        enable = 1'b0;
        tick;
        check_outs("rst_accum", 0, 0, 0, 0);
        check("rst_accum_ch", 32'(adc_ch), 0);
        check("rst_accum_start", 32'(adc_start), 0);
        check("rst_accum_fv", 32'(frame_valid), 0);
        check("rst_accum_to", 32'(adc_timeout), 0);
        rst = 1'b0;
        fv0 = fv_cnt;
        st0 = st_cnt;
        spur_seq++;
        repeat (10) tick;
        check("post_rst_no_fv", 32'(fv_cnt), 32'(fv0));
        check("post_rst_no_start", 32'(st_cnt), 32'(st0));
        check_outs("post_rst", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ldr_scan_sequencer.md
LDR_SCAN_SEQUENCER -- requirements
Module: ldr_scan_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE, default 16, mux settle cycles before the first conversion on each channel (1..255).
REQ-002 SHALL provide parameter AVG_LOG2, default 2, log2 of conversions averaged per channel (0..4).
REQ-003 SHALL provide parameter TIMEOUT, default 1024, maximum cycles spent in WAIT per conversion (2..65535).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  scanning permitted when high.
REQ-007 adc_done  input  1  one-cycle conversion-complete strobe from shared ADC.
REQ-008 adc_data  input  12  conversion result, valid only while adc_done=1.
REQ-009 adc_start  output  1  one-cycle conversion request to ADC.
REQ-010 adc_ch  output  2  analog mux select: 0=vertical_1, 1=vertical_2, 2=horizontal_1, 3=horizontal_2.
REQ-011 r_v1, r_v2, r_h1, r_h2  output  16 each  averaged photoresistor readings for the motion controller.
REQ-012 frame_valid  output  1  one-cycle pulse when all four readings update together.
REQ-013 adc_timeout  output  1  sticky conversion-timeout flag.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, START, WAIT, ACCUM, NEXT.
REQ-015 IDLE: adc_ch=0, counters cleared; enable=1 -> SETTLE next cycle.
REQ-016 SETTLE: SHALL stay exactly SETTLE cycles, then -> START.
REQ-017 START: adc_start=1 for exactly one cycle, -> WAIT; adc_start SHALL be 0 in every other state.
REQ-018 WAIT: adc_done=1 -> capture adc_data, -> ACCUM; adc_done outside WAIT SHALL be ignored.
REQ-019 ACCUM: accumulator += zero-extended sample (16-bit accumulator, no overflow for AVG_LOG2<=4); if samples taken < 2^AVG_LOG2 -> START, else -> NEXT.
REQ-020 NEXT: shadow[adc_ch] = accumulator >> AVG_LOG2 (truncating, zero-extended to 16 bits); clear accumulator and sample count.
REQ-021 NEXT with adc_ch<3: adc_ch+1, -> SETTLE.
REQ-022 NEXT with adc_ch=3: copy all four shadows to r_v1..r_h2 in the same cycle, pulse frame_valid, adc_ch wraps to 0, -> SETTLE if enable else IDLE.
REQ-023 adc_ch SHALL remain constant from entry into SETTLE until NEXT.
REQ-024 Outputs r_* SHALL change only on frame commit; partial frames never visible.
REQ-025 Timing: each conversion costs START(1)+WAIT(L, done in last cycle)+ACCUM(1); each channel costs SETTLE + 2^AVG_LOG2*(L+2) + 1 cycles.
REQ-026 enable deasserted in SETTLE, START->WAIT excluded: -> IDLE next cycle; in START/WAIT/ACCUM: complete current conversion (await adc_done or timeout), then -> IDLE; partial frame discarded, no frame_valid.
REQ-027 WAIT cycle count reaching TIMEOUT without adc_done: set adc_timeout=1, discard partial frame, adc_ch=0, -> SETTLE (or IDLE if enable=0).
REQ-028 adc_timeout SHALL clear only on rst.
REQ-029 enable reasserted in IDLE SHALL restart at channel 0.

Reset
REQ-030 rst=1 SHALL force state IDLE, adc_start=0, adc_ch=0, r_v1=r_v2=r_h1=r_h2=0, frame_valid=0, adc_timeout=0, accumulators, shadows and counters cleared, overriding all other inputs that cycle.
REQ-031 rst mid-conversion SHALL abandon it; a later adc_done SHALL be ignored unless in WAIT.

Verification
REQ-032 Defaults, ADC model L=5, constant data 100/200/300/400 per channel -> r_v1=100, r_v2=200, r_h1=300, r_h2=400; frame_valid pulses exactly 180 cycles apart; adc_ch sequence 0,1,2,3,0.
REQ-033 Channel 0 samples 10,11,12,13 -> r_v1=11 (sum 46, truncated); AVG_LOG2=0, sample 4095 -> r_v1=4095.
REQ-034 ADC never returns adc_done -> adc_timeout=1 after 1024 WAIT cycles; r_* hold prior values; no frame_valid; scanning restarts at channel 0.
REQ-035 enable dropped during WAIT on channel 2 -> adc_done still consumed, then IDLE; no frame_valid; r_* unchanged; re-enable -> next frame begins on channel 0.
REQ-036 rst asserted during ACCUM on channel 3 -> next cycle all outputs zero, state IDLE; spurious adc_done afterwards causes no change.
REQ-037 adc_done pulsed in SETTLE -> ignored; accumulated value and sample count unchanged.
